// File: rtl/stereo_mix_sched.sv
// FM stereo matrix scheduler: one shared adder/subtractor turns (L+R, L-R) pairs into left/right words.
// Define STEREO_SAT_EN for saturating arithmetic and the sticky sat_flag output; otherwise results wrap.
module stereo_mix_sched #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  lpr_dout,
    input  logic                   lpr_empty,
    output logic                   lpr_rd_en,
    input  logic [DATA_WIDTH-1:0]  lmr_dout,
    input  logic                   lmr_empty,
    output logic                   lmr_rd_en,
    input  logic                   mono,
    output logic [DATA_WIDTH-1:0]  left_din,
    input  logic                   left_full,
    output logic                   left_wr_en,
    output logic [DATA_WIDTH-1:0]  right_din,
    input  logic                   right_full,
    output logic                   right_wr_en,
    output logic [COUNT_WIDTH-1:0] pair_count
`ifdef STEREO_SAT_EN
    ,
    output logic                   sat_flag
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] lpr_q, lmr_q;
    logic                  mono_q;
    logic                  fetch;
    logic                  alu_sub;
    logic [DATA_WIDTH-1:0] alu_b, alu_sum, alu_res;

    // Shared ALU: mono zeroes the L-R operand so both channels carry L+R.
    assign alu_sub = (state == S_RIGHT);
    assign alu_b   = mono_q ? '0 : lmr_q;
    assign alu_sum = alu_sub ? (lpr_q - alu_b) : (lpr_q + alu_b);

`ifdef STEREO_SAT_EN
    logic alu_ovf;
    // For subtract, the effective second operand is -b, so its sign is inverted.
    assign alu_ovf = (lpr_q[DATA_WIDTH-1] == (alu_b[DATA_WIDTH-1] ^ alu_sub)) &&
                     (alu_sum[DATA_WIDTH-1] != lpr_q[DATA_WIDTH-1]);
    assign alu_res = alu_ovf ? {lpr_q[DATA_WIDTH-1], {(DATA_WIDTH-1){~lpr_q[DATA_WIDTH-1]}}}
                             : alu_sum;
`else
    assign alu_res = alu_sum;
`endif

    always_comb begin
        state_nxt   = state;
        fetch       = 1'b0;
        left_wr_en  = 1'b0;
        right_wr_en = 1'b0;
        left_din    = '0;
        right_din   = '0;
        case (state)
            S_FETCH: begin
                if (!lpr_empty && !lmr_empty) begin
                    fetch     = 1'b1;
                    state_nxt = S_LEFT;
                end
            end
            S_LEFT: begin
                if (!left_full) begin
                    left_wr_en = 1'b1;
                    left_din   = alu_res;
                    state_nxt  = S_RIGHT;
                end
            end
            S_RIGHT: begin
                if (!right_full) begin
                    right_wr_en = 1'b1;
                    right_din   = alu_res;
                    // Refetch in the same cycle keeps the 2-cycle-per-pair cadence.
                    if (!lpr_empty && !lmr_empty) begin
                        fetch     = 1'b1;
                        state_nxt = S_LEFT;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            default: state_nxt = S_FETCH;
        endcase
        lpr_rd_en = fetch;
        lmr_rd_en = fetch;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            lpr_q      <= '0;
            lmr_q      <= '0;
            mono_q     <= 1'b0;
            pair_count <= '0;
        end else begin
            state <= state_nxt;
            if (fetch) begin
                lpr_q  <= lpr_dout;
                lmr_q  <= lmr_dout;
                mono_q <= mono;
            end
            if (right_wr_en)
                pair_count <= pair_count + 1'b1;
        end
    end

`ifdef STEREO_SAT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sat_flag <= 1'b0;
        else if ((left_wr_en || right_wr_en) && alu_ovf)
            sat_flag <= 1'b1;
    end
`endif

endmodule
